multiport_regfile: RTL and testbench

MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

---
 rtl/multiport_regfile.sv | 82 ++++++++
 tb/tb_multiport_regfile.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multiport_regfile.sv
// multiport_regfile: 2-write / NUM_RD-read register file with per-register busy scoreboard.
// Define MULTIPORT_REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module multiport_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     rsv_valid,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ready,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [ADDR_W:0]          busy_cnt
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy, busy_n, set, clr;
    logic [ADDR_W:0]   cnt_n;
    logic              rsv_fire;

    assign rsv_ready = rsv_valid & ((rsv_addr == '0) | ~busy[rsv_addr]);
    assign rsv_fire  = rsv_ready & (rsv_addr != '0);

    // A reservation only lands on a non-busy bit, so recounting busy_n matches the +1/-1 rule
    always_comb begin
        set = '0;
        clr = '0;
        for (int i = 1; i < DEPTH; i++) begin
            set[i] = rsv_fire & (rsv_addr == ADDR_W'(i));
            clr[i] = (we0 & (wa0 == ADDR_W'(i))) | (we1 & (wa1 == ADDR_W'(i)));
        end
        busy_n = set | (busy & ~clr);
        cnt_n = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_n = cnt_n + (ADDR_W+1)'(busy_n[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            busy     <= busy_n;
            busy_cnt <= cnt_n;
            for (int i = 1; i < DEPTH; i++)
                if (we1 && wa1 == ADDR_W'(i))
                    mem[i] <= wd1;
                else if (we0 && wa0 == ADDR_W'(i))
                    mem[i] <= wd0;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] a;
            assign a = ra[k*ADDR_W +: ADDR_W];
`ifdef MULTIPORT_REGFILE_BYPASS_EN
            logic h0, h1;
            assign h0 = we0 & (wa0 == a);
            assign h1 = we1 & (wa1 == a);
            assign rd[k*DATA_W +: DATA_W] = (a == '0) ? '0 : h1 ? wd1 : h0 ? wd0 : mem[a];
            assign rd_busy[k] = (h0 | h1) ? set[a] : busy[a];
`else
            assign rd[k*DATA_W +: DATA_W] = (a == '0) ? '0 : mem[a];
            assign rd_busy[k] = busy[a];
`endif
        end
    endgenerate
endmodule

// File: tb/tb_multiport_regfile.sv
// tb_multiport_regfile: directed checks of writes, scoreboard reservations, reset and bypass.
module tb_multiport_regfile;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic          clk = 0;
    logic          rst = 1;
    logic          we0 = 0, we1 = 0, rsv_valid = 0;
    logic [AW-1:0] wa0 = 0, wa1 = 0, rsv_addr = 0;
    logic [DW-1:0] wd0 = 0, wd1 = 0;
    logic [NR*AW-1:0] ra = 0;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rd_busy;
    logic             rsv_ready;
    logic [AW:0]      busy_cnt;
    int checks = 0;
    int errors = 0;

    multiport_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
        .ra(ra), .rd(rd), .rd_busy(rd_busy), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; rsv_valid = 0;
    endtask

    initial begin
        edge1();
        check("rst_cnt", busy_cnt, 0);
        check("rst_rd", rd, 0);
        rst = 0;
        #1;
        check("rst_ready", rsv_ready, 0);
        for (int a = 0; a < (1 << AW); a++) begin
            ra = {AW'(a), AW'(a)};
            #1;
            check("init_rd", rd, 0);
            check("init_busy", rd_busy, 0);
        end
        check("init_cnt", busy_cnt, 0);

        we0 = 1; wa0 = 3; wd0 = 32'hAAAA0001;
        we1 = 1; wa1 = 3; wd1 = 32'h55550002;
        edge1();
        idle();
        ra = {AW'(0), AW'(3)};
        #1;
        check("ww_collide", rd[31:0], 32'h55550002);
        check("rd_zero", rd[63:32], 0);

        rsv_valid = 1; rsv_addr = 7;
        #1;
        check("rsv7_ready", rsv_ready, 1);
        edge1();
        check("rsv7_again", rsv_ready, 0);
        check("rsv7_cnt", busy_cnt, 1);
        ra = {AW'(7), AW'(3)};
        #1;
        check("rsv7_busy", rd_busy, 2'b10);
        rsv_valid = 0;
        we0 = 1; wa0 = 7; wd0 = 32'h12345678;
        #1;
`ifdef MULTIPORT_REGFILE_BYPASS_EN
        check("w7_pre_rd", rd[63:32], 32'h12345678);
        check("w7_pre_busy", rd_busy, 2'b00);
`else
        check("w7_pre_rd", rd[63:32], 0);
        check("w7_pre_busy", rd_busy, 2'b10);
`endif
        edge1();
        idle();
        #1;
        check("w7_cnt", busy_cnt, 0);
        check("w7_busy", rd_busy, 0);
        check("w7_rd", rd[63:32], 32'h12345678);

        rsv_valid = 1; rsv_addr = 9;
        we1 = 1; wa1 = 9; wd1 = 32'hDEADBEEF;
        ra = {AW'(9), AW'(9)};
        #1;
        check("rw9_ready", rsv_ready, 1);
`ifdef MULTIPORT_REGFILE_BYPASS_EN
        check("rw9_pre_busy", rd_busy, 2'b11);
`endif
        edge1();
        idle();
        #1;
        check("rw9_busy", rd_busy, 2'b11);
        check("rw9_rd", rd[31:0], 32'hDEADBEEF);
        check("rw9_cnt", busy_cnt, 1);

        we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF;
        rsv_valid = 1; rsv_addr = 0;
        ra = {AW'(0), AW'(0)};
        #1;
        check("r0_ready", rsv_ready, 1);
        edge1();
        idle();
        #1;
        check("r0_rd", rd, 0);
        check("r0_busy", rd_busy, 0);
        check("r0_cnt", busy_cnt, 1);

        we0 = 1; wa0 = 10; wd0 = 32'h0000A10A;
        we1 = 1; wa1 = 11; wd1 = 32'h0000B11B;
        edge1();
        idle();
        ra = {AW'(11), AW'(10)};
        #1;
        check("dual_wr", rd, {32'h0000B11B, 32'h0000A10A});
        check("nobusy_wr_cnt", busy_cnt, 1);

        rsv_valid = 1; rsv_addr = 12;
        we0 = 1; wa0 = 9; wd0 = 32'h99999999;
        edge1();
        idle();
        ra = {AW'(12), AW'(9)};
        #1;
        check("setclr_cnt", busy_cnt, 1);
        check("setclr_busy", rd_busy, 2'b10);
        check("setclr_rd", rd[31:0], 32'h99999999);

        rsv_valid = 1; rsv_addr = 4;
        edge1();
        rsv_addr = 5;
        edge1();
        idle();
        ra = {AW'(5), AW'(4)};
        #1;
        check("pre_rst_cnt", busy_cnt, 3);
        check("pre_rst_busy", rd_busy, 2'b11);
        #2;
        rst = 1;
        #1;
        check("async_cnt", busy_cnt, 0);
        check("async_busy", rd_busy, 0);
        ra = {AW'(12), AW'(3)};
        #1;
        check("async_rd", rd, 0);
        #2;
        rst = 0;
        we0 = 1; wa0 = 4; wd0 = 32'hCAFEF00D;
        ra = {AW'(5), AW'(4)};
        #1;
`ifdef MULTIPORT_REGFILE_BYPASS_EN
        check("byp4_rd", rd[31:0], 32'hCAFEF00D);
`else
        check("byp4_rd", rd[31:0], 0);
`endif
        edge1();
        idle();
        #1;
        check("w4_rd", rd[31:0], 32'hCAFEF00D);
        check("w4_cnt", busy_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
